// File: rtl/interpolator_pkg.sv
// Shared types and helpers for the interpolator.
// INTERP_LINEAR_EN selects linear interpolation; without it the block
// performs a zero-order hold.
package interpolator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_EMIT = 2'd2
    } interp_state_t;

    // Width of the factor-minus-one / burst index counter.
    function automatic int cnt_width(input int max_n);
        return (max_n > 1) ? $clog2(max_n) : 1;
    endfunction

    // Signed accumulator width: W data bits, one for the difference, one guard, D fraction.
    function automatic int acc_width(input int w, input int d);
        return w + 2 + d;
    endfunction

    localparam int DEF_CNT_W = cnt_width(10);
    localparam int DEF_ACC_W = acc_width(14, 28);

    // floor(2^d / n), evaluated only on constants at elaboration time.
    function automatic logic [63:0] recip(input int n, input int d);
        return (64'd1 << d) / 64'(n);
    endfunction

endpackage

// File: rtl/interp_step_mult.sv
// Registered signed x unsigned multiply with load enable, 1-cycle latency.
module interp_step_mult #(
    parameter int A_W = 15,
    parameter int B_W = 29
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic signed [A_W-1:0]     a,
    input  logic        [B_W-1:0]     b,
    output logic signed [A_W+B_W-1:0] p
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;

    // b is zero-extended so it is treated as unsigned in the signed product.
    assign a_ext = P_W'(a);
    assign b_ext = $signed(P_W'(b));

    // Product register; held between loads so it serves as the burst step.
    always_ff @(posedge clk) begin
        if (en) begin
            p <= a_ext * b_ext;
        end
    end

endmodule

// File: rtl/interpolator.sv
// Upsampling interpolator: one input sample expands into a burst of N outputs.
// INTERP_LINEAR_EN defined: linear ramp from the previous to the current input.
// INTERP_LINEAR_EN undefined: zero-order hold (every burst sample equals the input).
module interpolator
    import interpolator_pkg::*;
#(
    parameter int INT_MAX_INTERP_BY = 10,
    parameter int INT_IN_DATA_WIDTH = 14,
    parameter int INT_DIVISOR_WIDTH = 28
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    input  logic signed [INT_IN_DATA_WIDTH-1:0]    i_data,
    input  logic                                   i_interp_cmd_valid,
    input  logic [$clog2(INT_MAX_INTERP_BY)-1:0]   i_interp_cmd_data,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic signed [INT_IN_DATA_WIDTH-1:0]    o_data,
    output logic                                   o_last
);

    localparam int W     = INT_IN_DATA_WIDTH;
    localparam int D     = INT_DIVISOR_WIDTH;
    localparam int CW    = cnt_width(INT_MAX_INTERP_BY);
    localparam int ACC_W = acc_width(W, D);
    localparam logic [CW-1:0] N_MAX_M1 = CW'(INT_MAX_INTERP_BY - 1);

    interp_state_t state;
    logic [CW-1:0] n_m1;
    logic [CW-1:0] j;
    logic [CW-1:0] j_nx;
    logic [CW-1:0] cmd_n_m1;
    logic          accept;
    logic          out_hs;

    assign o_ready  = !rst && !i_interp_cmd_valid && (state == ST_IDLE);
    assign accept   = i_valid && o_ready;
    assign out_hs   = o_valid && i_ready;
    assign j_nx     = j + 1'b1;
    assign cmd_n_m1 = (i_interp_cmd_data > N_MAX_M1) ? N_MAX_M1 : i_interp_cmd_data;

`ifdef INTERP_LINEAR_EN
    localparam int RW = D + 1;
    localparam int DW = W + 1;
    localparam logic signed [ACC_W-1:0] HALF = {{(ACC_W-D){1'b0}}, 1'b1, {(D-1){1'b0}}};

    logic signed [W-1:0]     prev;
    logic signed [W-1:0]     cur;
    logic signed [DW-1:0]    diff;
    logic        [RW-1:0]    recip_tab [INT_MAX_INTERP_BY];
    logic        [RW-1:0]    recip_sel;
    logic signed [ACC_W-1:0] step;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] first;
    logic signed [ACC_W-1:0] acc_nx;

    for (genvar k = 0; k < INT_MAX_INTERP_BY; k++) begin : g_recip
        assign recip_tab[k] = RW'(recip(k + 1, D));
    end

    assign recip_sel = recip_tab[n_m1];
    assign diff      = DW'(i_data) - DW'(prev);
    assign first     = (ACC_W'(prev) <<< D) + step;
    assign acc_nx    = acc + step;

    // Step is loaded on the accepting edge and held for the whole burst.
    interp_step_mult #(
        .A_W (DW),
        .B_W (RW)
    ) u_step_mult (
        .clk (clk),
        .en  (accept),
        .a   (diff),
        .b   (recip_sel),
        .p   (step)
    );

    function automatic logic signed [W-1:0] rnd(input logic signed [ACC_W-1:0] x);
        return W'((x + HALF) >>> D);
    endfunction
`endif

    // Control FSM with registered output stage; acc always tracks the sample on o_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            n_m1    <= N_MAX_M1;
            j       <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
`ifdef INTERP_LINEAR_EN
            prev    <= '0;
            cur     <= '0;
            acc     <= '0;
`endif
        end else if (i_interp_cmd_valid) begin
            n_m1    <= cmd_n_m1;
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        j <= '0;
`ifdef INTERP_LINEAR_EN
                        cur   <= i_data;
                        state <= ST_CALC;
`else
                        state   <= ST_EMIT;
                        o_valid <= 1'b1;
                        o_data  <= i_data;
                        o_last  <= (n_m1 == '0);
`endif
                    end
                end
`ifdef INTERP_LINEAR_EN
                ST_CALC: begin
                    state   <= ST_EMIT;
                    o_valid <= 1'b1;
                    acc     <= first;
                    if (n_m1 == '0) begin
                        o_data <= cur;
                        o_last <= 1'b1;
                    end else begin
                        o_data <= rnd(first);
                        o_last <= 1'b0;
                    end
                end
`endif
                ST_EMIT: begin
                    if (out_hs) begin
                        if (j == n_m1) begin
                            state   <= ST_IDLE;
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
`ifdef INTERP_LINEAR_EN
                            prev    <= cur;
`endif
                        end else begin
                            j      <= j_nx;
                            o_last <= (j_nx == n_m1);
`ifdef INTERP_LINEAR_EN
                            acc    <= acc_nx;
                            o_data <= (j_nx == n_m1) ? cur : rnd(acc_nx);
`endif
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interpolator.sv
// Self-checking bench for interpolator; expectations come from a burst model
// built directly from the ramp formula (linear) or sample repetition (hold).
module tb_interpolator;

    localparam int MAXN = 10;
    localparam int W    = 14;
    localparam int D    = 28;
    localparam int CW   = $clog2(MAXN);

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_valid = 1'b0;
    logic                 o_ready;
    logic signed [W-1:0]  i_data = '0;
    logic                 i_interp_cmd_valid = 1'b0;
    logic [CW-1:0]        i_interp_cmd_data = '0;
    logic                 o_valid;
    logic                 i_ready;
    logic signed [W-1:0]  o_data;
    logic                 o_last;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   prev_m = 0;
    int   n_m    = MAXN;
    int   bp_mode = 0;
    int   bp_ph   = 0;
    bit   hold_pend = 1'b0;
    int   hold_d = 0;
    int   hold_l = 0;

    interpolator #(
        .INT_MAX_INTERP_BY (MAXN),
        .INT_IN_DATA_WIDTH (W),
        .INT_DIVISOR_WIDTH (D)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_valid            (i_valid),
        .o_ready            (o_ready),
        .i_data             (i_data),
        .i_interp_cmd_valid (i_interp_cmd_valid),
        .i_interp_cmd_data  (i_interp_cmd_data),
        .o_valid            (o_valid),
        .i_ready            (i_ready),
        .o_data             (o_data),
        .o_last             (o_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Expected burst for one accepted input, from the ramp definition.
    function automatic void push_burst(input int cur, input int prv, input int n);
        exp_t   e;
        longint dlt;
        longint rcp;
        longint stp;
        longint a;
        for (int k = 1; k < n; k++) begin
`ifdef INTERP_LINEAR_EN
            dlt = longint'(cur) - longint'(prv);
            rcp = (longint'(1) <<< D) / longint'(n);
            stp = dlt * rcp;
            a   = (longint'(prv) <<< D) + longint'(k) * stp;
            e.data = int'((a + (longint'(1) <<< (D - 1))) >>> D);
`else
            e.data = cur;
`endif
            e.last = 1'b0;
            exp_q.push_back(e);
        end
        e.data = cur;
        e.last = 1'b1;
        exp_q.push_back(e);
    endfunction

    // Downstream ready pattern generator.
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1: i_ready = 1'($urandom_range(0, 1));
                2: begin
                    i_ready = (bp_ph == 0);
                    bp_ph   = (bp_ph + 1) % 3;
                end
                default: i_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: scoreboard on handshakes, stability while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (hold_pend) begin
            chk("hold_valid", int'(o_valid), 1);
            chk("hold_data", int'(o_data), hold_d);
            chk("hold_last", int'(o_last), hold_l);
        end
        hold_pend = 1'b0;
        if (!rst && !i_interp_cmd_valid && o_valid) begin
            if (i_ready) begin
                chk("out_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", int'(o_data), e.data);
                    chk("out_last", int'(o_last), int'(e.last));
                    if (e.last) prev_m = e.data;
                end
            end else begin
                hold_pend = 1'b1;
                hold_d    = int'(o_data);
                hold_l    = int'(o_last);
            end
        end
    end

    task automatic send(input int x, input bit lat_chk);
        int k = 0;
        bit done = 1'b0;
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_data  = W'(x);
        while (!done) begin
            @(negedge clk);
            if (o_ready) begin
                push_burst(x, prev_m, n_m);
                done = 1'b1;
            end else if (k >= 300) begin
                chk("send_timeout", int'(o_ready), 1);
                done = 1'b1;
            end
            k++;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (lat_chk) begin
            @(negedge clk);
`ifdef INTERP_LINEAR_EN
            chk("lat_calc_cycle", int'(o_valid), 0);
            @(negedge clk);
            chk("lat_first_out", int'(o_valid), 1);
`else
            chk("lat_first_out", int'(o_valid), 1);
`endif
        end
    endtask

    task automatic cmd(input logic [CW-1:0] c);
        @(posedge clk);
        #1;
        i_interp_cmd_valid = 1'b1;
        i_interp_cmd_data  = c;
        @(negedge clk);
        chk("cmd_blocks_ready", int'(o_ready), 0);
        @(posedge clk);
        exp_q.delete();
        n_m = ((int'(c) < MAXN - 1) ? int'(c) : MAXN - 1) + 1;
        #1;
        i_interp_cmd_valid = 1'b0;
        @(negedge clk);
        chk("cmd_abort_valid", int'(o_valid), 0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || o_valid) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic rst_pulse(input int cycles);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            chk("rst_ready", int'(o_ready), 0);
            @(posedge clk);
        end
        exp_q.delete();
        prev_m = 0;
        n_m    = MAXN;
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_data", int'(o_data), 0);
        chk("rst_last", int'(o_last), 0);
        chk("rst_ready_after", int'(o_ready), 1);
    endtask

    initial begin
        rst_pulse(3);

        // Directed ramps and rounding
        cmd(4'd3);
        send(100, 1'b1);
        wait_idle();
        send(-100, 1'b0);
        wait_idle();
        cmd(4'd2);
        send(30, 1'b1);
        wait_idle();
        send(7, 1'b0);
        wait_idle();
        cmd(4'd0);
        send(-8192, 1'b1);
        wait_idle();

        // Backpressure 1,0,0 pattern
        cmd(4'd3);
        bp_mode = 2;
        send(55, 1'b0);
        wait_idle();
        bp_mode = 0;

        // Command mid-burst, then a 2-sample burst from unchanged prev
        send(1000, 1'b0);
        repeat (3) @(posedge clk);
        cmd(4'd1);
        send(40, 1'b0);
        wait_idle();

        // Command and input in the same cycle, clamped factor
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_data  = W'(77);
        i_interp_cmd_valid = 1'b1;
        i_interp_cmd_data  = 4'd15;
        @(negedge clk);
        chk("cmd_vs_input_ready", int'(o_ready), 0);
        @(posedge clk);
        n_m = MAXN;
        #1;
        i_valid = 1'b0;
        i_interp_cmd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("dropped_input_quiet", int'(o_valid), 0);
        end
        send(500, 1'b0);
        wait_idle();

        // Reset mid-burst, then confirm prev restarted from zero
        send(200, 1'b0);
        repeat (3) @(posedge clk);
        rst_pulse(1);
        send(123, 1'b0);
        wait_idle();

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            bp_mode = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) cmd(CW'($urandom_range(0, 15)));
            send(int'($urandom_range(0, 16383)) - 8192, 1'b0);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 6)) @(posedge clk);
                cmd(CW'($urandom_range(0, 15)));
            end else begin
                wait_idle();
            end
        end
        bp_mode = 0;
        wait_idle();
        chk("queue_empty_end", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
